// File: rtl/intc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : intc_ctrl
// Purpose  : Memory-mapped interrupt controller between peripheral interrupt
//            sources and the CPU's 8-bit one-hot interrupt input. Each channel
//            has a 3-flop synchroniser, edge/level mode, enable mask, pending
//            latch (write-1-to-clear), software force and fixed priority
//            (lowest index wins).
// Ports    : clk       - system clock
//            rst_n     - asynchronous active-low reset
//            src_in    - raw interrupt requests (async, active-high)
//            bus_addr  - CPU data address
//            bus_we    - write strobe
//            bus_wd    - write data
//            bus_rd    - combinational read data (0 when not decoded)
//            int_vec   - registered one-hot interrupt vector to the CPU
// Register map (word offset bus_addr[2:0]):
//            0 PEND (W1C)  1 EN  2 MODE (1=edge)  3 ID (RO)  4 FORCE (WO)
//            5..7 reserved, read 0
// Revision : 1.0 - initial release
// ============================================================================
module intc_ctrl #(
  parameter int          NUM_SRC   = 8,
  parameter logic [15:0] BASE_ADDR = 16'hFF40
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] src_in,
  input  logic [15:0]        bus_addr,
  input  logic               bus_we,
  input  logic [15:0]        bus_wd,
  output logic [15:0]        bus_rd,
  output logic [7:0]         int_vec
);

  localparam logic [2:0] OFF_PEND  = 3'd0;
  localparam logic [2:0] OFF_EN    = 3'd1;
  localparam logic [2:0] OFF_MODE  = 3'd2;
  localparam logic [2:0] OFF_ID    = 3'd3;
  localparam logic [2:0] OFF_FORCE = 3'd4;

  logic [NUM_SRC-1:0] s1_q, s1_d;
  logic [NUM_SRC-1:0] s2_q, s2_d;
  logic [NUM_SRC-1:0] s3_q, s3_d;
  logic [NUM_SRC-1:0] pend_q, pend_d;
  logic [NUM_SRC-1:0] en_q, en_d;
  logic [NUM_SRC-1:0] mode_q, mode_d;
  logic [7:0]         int_vec_q, int_vec_d;

  logic               hit;
  logic [2:0]         off;
  logic [NUM_SRC-1:0] wd;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr;
  logic [NUM_SRC-1:0] frc;
  logic [NUM_SRC-1:0] edge_next;
  logic [NUM_SRC-1:0] sel;
  logic [2:0]         id;
  logic               unused_wd;

  // Upper write-data bits beyond NUM_SRC are intentionally ignored.
  assign unused_wd = ^bus_wd;

  assign hit = (bus_addr[15:3] == BASE_ADDR[15:3]);
  assign off = bus_addr[2:0];
  assign wd  = bus_wd[NUM_SRC-1:0];

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    s1_d      = src_in;
    s2_d      = s1_q;
    s3_d      = s2_q;
    en_d      = en_q;
    mode_d    = mode_q;
    int_vec_d = '0;

    rise = s2_q & ~s3_q;
    clr  = (bus_we && hit && off == OFF_PEND)  ? wd : '0;
    frc  = (bus_we && hit && off == OFF_FORCE) ? wd : '0;

    // Edge channels: set (rise or force) dominates a simultaneous clear.
    edge_next = (pend_q & ~clr) | rise | frc;
    // Level channels simply mirror the synchronised source every cycle,
    // which also makes W1C and FORCE no-ops for them.
    pend_d = (mode_q & edge_next) | (~mode_q & s2_q);

    if (bus_we && hit && off == OFF_EN)   en_d   = wd;
    if (bus_we && hit && off == OFF_MODE) mode_d = wd;

    // Fixed priority: scan from the top so the lowest set index is left last.
    sel = pend_q & en_q;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (sel[i]) begin
        int_vec_d    = '0;
        int_vec_d[i] = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q      <= '0;
      s2_q      <= '0;
      s3_q      <= '0;
      pend_q    <= '0;
      en_q      <= '0;
      mode_q    <= '0;
      int_vec_q <= '0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      s3_q      <= s3_d;
      pend_q    <= pend_d;
      en_q      <= en_d;
      mode_q    <= mode_d;
      int_vec_q <= int_vec_d;
    end
  end

  assign int_vec = int_vec_q;

  // --------------------------------------------------------------------------
  // Read path (combinational, zero-extended)
  // --------------------------------------------------------------------------
  always_comb begin
    id = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (int_vec_q[i]) id = 3'(i);
    end

    bus_rd = '0;
    if (hit) begin
      case (off)
        OFF_PEND: bus_rd[NUM_SRC-1:0] = pend_q;
        OFF_EN:   bus_rd[NUM_SRC-1:0] = en_q;
        OFF_MODE: bus_rd[NUM_SRC-1:0] = mode_q;
        OFF_ID:   bus_rd = {(|int_vec_q), 12'b0, id};
        default:  bus_rd = '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_intc_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_intc_ctrl
// Purpose  : Directed self-checking bench for intc_ctrl (NUM_SRC=8 and 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_intc_ctrl;

  localparam logic [15:0] BASE = 16'hFF40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic [7:0]  src_in = 8'h00;
  logic [15:0] bus_addr = 16'h0000;
  logic        bus_we = 1'b0;
  logic [15:0] bus_wd = 16'h0000;
  logic [15:0] bus_rd;
  logic [7:0]  int_vec;

  logic [2:0]  src3 = 3'b000;
  logic [15:0] addr3 = 16'h0000;
  logic        we3 = 1'b0;
  logic [15:0] wd3 = 16'h0000;
  logic [15:0] rd3;
  logic [7:0]  vec3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  intc_ctrl #(.NUM_SRC(8), .BASE_ADDR(BASE)) u_dut (
    .clk(clk), .rst_n(rst_n), .src_in(src_in), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_wd(bus_wd), .bus_rd(bus_rd), .int_vec(int_vec)
  );

  intc_ctrl #(.NUM_SRC(3), .BASE_ADDR(BASE)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .src_in(src3), .bus_addr(addr3),
    .bus_we(we3), .bus_wd(wd3), .bus_rd(rd3), .int_vec(vec3)
  );

  task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 16'h%04h expected 16'h%04h", tag, act, exp);
    end
  endtask

  // Advance n rising edges, landing 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [2:0] offs, output logic [15:0] val);
    bus_addr = BASE + 16'(offs);
    #1;
    val = bus_rd;
  endtask

  // Write is captured on the next edge; returns 1 unit after that edge.
  task automatic wr(input logic [2:0] offs, input logic [15:0] data);
    bus_addr = BASE + 16'(offs);
    bus_wd   = data;
    bus_we   = 1'b1;
    step(1);
    bus_we   = 1'b0;
  endtask

  initial begin
    logic [15:0] v;

    // ---------------- reset ----------------
    src_in = 8'hFF;
    step(3);
    check("rst_int_vec", {8'h00, int_vec}, 16'h0000);
    check("rst_int_vec3", {8'h00, vec3}, 16'h0000);
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), v);
      check($sformatf("rst_rd%0d", i), v, 16'h0000);
    end
    rst_n = 1'b1;
    step(4);
    rd(3'd0, v);
    check("lvl_pend_ff", v, 16'h00FF);
    check("en0_int_vec", {8'h00, int_vec}, 16'h0000);
    src_in = 8'h00;
    step(4);
    rd(3'd0, v);
    check("lvl_pend_clr", v, 16'h0000);

    // ---------------- edge latency and W1C ----------------
    wr(3'd2, 16'h0001);
    wr(3'd1, 16'h0001);
    src_in[0] = 1'b1;
    step(1);                 // edge k
    step(1);                 // k+1
    src_in[0] = 1'b0;
    step(1);                 // k+2
    rd(3'd0, v);
    check("edge_pend_k2", v, 16'h0001);
    check("edge_vec_k2", {8'h00, int_vec}, 16'h0000);
    step(1);                 // k+3
    check("edge_vec_k3", {8'h00, int_vec}, 16'h0001);
    rd(3'd3, v);
    check("edge_id", v, 16'h8000);
    wr(3'd0, 16'h0001);      // W1C at edge n
    rd(3'd0, v);
    check("w1c_pend", v, 16'h0000);
    check("w1c_vec_n", {8'h00, int_vec}, 16'h0001);
    step(1);
    check("w1c_vec_n1", {8'h00, int_vec}, 16'h0000);

    // ---------------- priority ----------------
    wr(3'd2, 16'h00FF);
    wr(3'd1, 16'h00FF);
    src_in = 8'h24;
    step(4);
    check("prio_vec", {8'h00, int_vec}, 16'h0004);
    rd(3'd3, v);
    check("prio_id", v, 16'h8002);
    wr(3'd0, 16'h0004);
    step(1);
    check("prio_next_vec", {8'h00, int_vec}, 16'h0020);
    rd(3'd3, v);
    check("prio_next_id", v, 16'h8005);
    wr(3'd0, 16'h0020);
    step(1);
    check("prio_clr_vec", {8'h00, int_vec}, 16'h0000);
    src_in = 8'h00;
    step(3);

    // ---------------- set wins over W1C ----------------
    src_in[3] = 1'b1;
    step(2);                 // after k+1: rise high this cycle
    wr(3'd0, 16'h0008);      // W1C lands on the rise cycle
    rd(3'd0, v);
    check("setwin_pend", v, 16'h0008);
    step(1);
    check("setwin_vec", {8'h00, int_vec}, 16'h0008);
    wr(3'd0, 16'h0008);
    step(1);
    check("setwin_clr_vec", {8'h00, int_vec}, 16'h0000);
    src_in = 8'h00;
    step(3);

    // ---------------- level and FORCE ----------------
    wr(3'd2, 16'h0000);
    wr(3'd1, 16'h0002);
    src_in[1] = 1'b1;
    step(4);
    check("lvl_vec", {8'h00, int_vec}, 16'h0002);
    wr(3'd0, 16'h0002);
    rd(3'd0, v);
    check("lvl_w1c_pend", v, 16'h0002);
    step(1);
    check("lvl_w1c_vec", {8'h00, int_vec}, 16'h0002);
    src_in[1] = 1'b0;
    step(3);
    check("lvl_drop_k2", {8'h00, int_vec}, 16'h0002);
    step(1);
    check("lvl_drop_k3", {8'h00, int_vec}, 16'h0000);
    wr(3'd2, 16'h0002);
    wr(3'd4, 16'h0002);      // FORCE at edge n
    check("force_vec_n", {8'h00, int_vec}, 16'h0000);
    step(1);
    check("force_vec_n1", {8'h00, int_vec}, 16'h0002);
    rd(3'd3, v);
    check("force_id", v, 16'h8001);
    rd(3'd4, v);
    check("force_rd0", v, 16'h0000);
    bus_addr = 16'hFF48;
    #1;
    check("nodecode_rd", bus_rd, 16'h0000);

    // Disabling keeps PEND; re-enable re-presents it.
    wr(3'd1, 16'h0000);
    step(1);
    check("dis_vec", {8'h00, int_vec}, 16'h0000);
    rd(3'd0, v);
    check("dis_pend", v, 16'h0002);
    wr(3'd1, 16'h0002);
    step(1);
    check("reen_vec", {8'h00, int_vec}, 16'h0002);

    // ---------------- NUM_SRC = 3 ----------------
    addr3 = BASE + 16'd1;
    wd3   = 16'hFFFF;
    we3   = 1'b1;
    step(1);
    we3   = 1'b0;
    #1;
    check("p3_en", rd3, 16'h0007);
    src3 = 3'b111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("p3_hi_bits%0d", i), {11'h000, vec3[7:3]}, 16'h0000);
    end
    check("p3_vec", {8'h00, vec3}, 16'h0001);
    addr3 = BASE + 16'd6;
    #1;
    check("p3_off6", rd3, 16'h0000);
    addr3 = BASE;
    #1;
    check("p3_pend", rd3, 16'h0007);

    // ---------------- async reset mid-operation ----------------
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vec", {8'h00, int_vec}, 16'h0000);
    rd(3'd0, v);
    check("arst_pend", v, 16'h0000);
    rd(3'd1, v);
    check("arst_en", v, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
